// File: rtl/pipe_pkg.sv
// Shared definitions for the valid/ready pipeline stage register.
//   - state_e      : occupancy state of a stage (EMPTY / ONE / TWO)
//   - CTRL_*       : bit positions of the ID/EX control bundle fields
//   - DATA_*       : bit offsets and widths of the ID/EX data bundle fields
package pipe_pkg;

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StTwo   = 2'd2
   } state_e;

   // ID/EX control bundle layout (CTRL_W = 8, bit 7 spare)
   localparam int unsigned CTRL_ULA_LSB    = 0;
   localparam int unsigned CTRL_ULA_W      = 2;
   localparam int unsigned CTRL_MUX_ULA    = 2;
   localparam int unsigned CTRL_MEM_RD     = 3;
   localparam int unsigned CTRL_MEM_WR     = 4;
   localparam int unsigned CTRL_REG_WR     = 5;
   localparam int unsigned CTRL_MUX_REG_WR = 6;

   // ID/EX data bundle layout; bits above DATA_USED_W are reserved for PC/PC+4
   localparam int unsigned DATA_IMM_LSB    = 0;
   localparam int unsigned DATA_IMM_W      = 32;
   localparam int unsigned DATA_RS1_LSB    = 32;
   localparam int unsigned DATA_RS2_LSB    = 37;
   localparam int unsigned DATA_RD_LSB     = 42;
   localparam int unsigned DATA_REG_W      = 5;
   localparam int unsigned DATA_FUNCT7_LSB = 47;
   localparam int unsigned DATA_FUNCT7_W   = 7;
   localparam int unsigned DATA_FUNCT3_LSB = 54;
   localparam int unsigned DATA_FUNCT3_W   = 3;
   localparam int unsigned DATA_VAL_A_LSB  = 57;
   localparam int unsigned DATA_VAL_B_LSB  = 89;
   localparam int unsigned DATA_VAL_W      = 32;
   localparam int unsigned DATA_USED_W     = 121;

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of a pipeline stage: control bundle plus data bundle.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (clears everything)
//   ld_i      : capture ctrl_i/data_i
//   clr_i     : invalidate entry; wins over ld_i. Clears control always,
//               data only when ZERO_DATA != 0
//   ctrl_i/o  : control bundle in / held value
//   data_i/o  : data bundle in / held value
module pipe_slot import pipe_pkg::*; #(
   parameter int unsigned CTRL_W    = 8,
   parameter int unsigned DATA_W    = 144,
   parameter int unsigned ZERO_DATA = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_i,
   input  logic              clr_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [DATA_W-1:0] data_o
);

   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [DATA_W-1:0] data_q, data_d;

   always_comb begin
      ctrl_d = ctrl_q;
      data_d = data_q;
      if (clr_i) begin
         ctrl_d = '0;
         if (ZERO_DATA != 0) data_d = '0;
      end else if (ld_i) begin
         ctrl_d = ctrl_i;
         data_d = data_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q <= '0;
         data_q <= '0;
      end else begin
         ctrl_q <= ctrl_d;
         data_q <= data_d;
      end
   end

   assign ctrl_o = ctrl_q;
   assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register carrying a control and a data bundle.
// With SKID_EN != 0 a second (skid) entry makes in_ready purely registered;
// with SKID_EN == 0 there is one entry and in_ready depends combinationally on
// out_ready (a timing path through this stage).
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : upstream handshake
//   in_ctrl/in_data     : upstream bundles
//   flush               : synchronous kill of held and incoming entries
//   out_valid/out_ready : downstream handshake
//   out_ctrl/out_data   : head entry (out_ctrl forced to 0 on bubbles)
//   stall_cnt           : saturating count of out_valid & !out_ready cycles
module pipe_stage_reg import pipe_pkg::*; #(
   parameter int unsigned CTRL_W    = 8,
   parameter int unsigned DATA_W    = 144,
   parameter int unsigned SKID_EN   = 1,
   parameter int unsigned ZERO_DATA = 0,
   parameter int unsigned CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   state_e            state_q, state_d;
   logic              live_q;
   logic              accept, issue;
   logic              main_ld, main_clr, main_from_skid;
   logic              skid_ld, skid_clr;
   logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_in;
   logic [DATA_W-1:0] main_data, skid_data, main_data_in;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   assign out_valid = (state_q != StEmpty);

   // live_q holds in_ready low while in reset and for the cycle rst falls in
   always_comb begin
      if (SKID_EN != 0) in_ready = live_q & (state_q != StTwo);
      else              in_ready = live_q & (~out_valid | out_ready);
   end

   assign accept = in_valid & in_ready;
   assign issue  = out_valid & out_ready;

   always_comb begin
      state_d        = state_q;
      main_ld        = 1'b0;
      main_clr       = 1'b0;
      main_from_skid = 1'b0;
      skid_ld        = 1'b0;
      skid_clr       = 1'b0;
      if (flush) begin
         // a concurrent issue still completes; incoming entry is dropped
         state_d  = StEmpty;
         main_clr = 1'b1;
         skid_clr = 1'b1;
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (accept) begin
                  main_ld = 1'b1;
                  state_d = StOne;
               end
            end
            StOne: begin
               if (accept && issue) begin
                  main_ld = 1'b1;
               end else if (issue) begin
                  main_clr = 1'b1;
                  state_d  = StEmpty;
               end else if (accept) begin
                  // only reachable with a skid entry; without one in_ready is low here
                  skid_ld = 1'b1;
                  state_d = StTwo;
               end
            end
            StTwo: begin
               if (issue) begin
                  main_ld        = 1'b1;
                  main_from_skid = 1'b1;
                  state_d        = StOne;
               end
            end
            default: state_d = StEmpty;
         endcase
      end
   end

   assign main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl;
   assign main_data_in = main_from_skid ? skid_data : in_data;

   pipe_slot #(
      .CTRL_W    (CTRL_W),
      .DATA_W    (DATA_W),
      .ZERO_DATA (ZERO_DATA)
   ) u_main (
      .clk    (clk),
      .rst    (rst),
      .ld_i   (main_ld),
      .clr_i  (main_clr),
      .ctrl_i (main_ctrl_in),
      .data_i (main_data_in),
      .ctrl_o (main_ctrl),
      .data_o (main_data)
   );

   if (SKID_EN != 0) begin : g_skid
      pipe_slot #(
         .CTRL_W    (CTRL_W),
         .DATA_W    (DATA_W),
         .ZERO_DATA (ZERO_DATA)
      ) u_skid (
         .clk    (clk),
         .rst    (rst),
         .ld_i   (skid_ld),
         .clr_i  (skid_clr),
         .ctrl_i (in_ctrl),
         .data_i (in_data),
         .ctrl_o (skid_ctrl),
         .data_o (skid_data)
      );
   end else begin : g_no_skid
      assign skid_ctrl = '0;
      assign skid_data = '0;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (out_valid && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StEmpty;
         live_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         live_q  <= 1'b1;
         cnt_q   <= cnt_d;
      end
   end

   // bubbles never present stale mem_wr/reg_wr downstream
   assign out_ctrl  = out_valid ? main_ctrl : '0;
   assign out_data  = main_data;
   assign stall_cnt = cnt_q;

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised valid/ready pipeline stage register.
- Replaces the fixed-field, enable-only inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) in the RV32I pipeline.
- Carries a control bundle and a data bundle, with optional 2-entry skid buffering so stalls do not need a combinational ready path.
- Synchronous flush inserts a bubble. A saturating counter records backpressure cycles for performance analysis.

Parameters:
- CTRL_W, 8: control bundle width. For ID/EX this is ula[1:0], mux_ula, mem_rd, mem_wr, reg_wr, mux_reg_wr, plus 1 spare.
- DATA_W, 144: data bundle width. For ID/EX this is imm, rs1, rs2, rd, funct7, funct3, val_A, val_B = 32+5+5+5+7+3+32+32 = 121, padded up to 144 to cover PC/PC+4 later.
- SKID_EN, 1: 1 = two entries with registered in_ready; 0 = single entry with pass-through ready.
- ZERO_DATA, 0: 1 = data bundle also cleared on flush/bubble; 0 = data held, only control cleared.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream has a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- flush  in  1  synchronous kill of all held and incoming entries (branch/jump mispredict).
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts the head entry.
- out_ctrl  out  CTRL_W  head control; forced to all-zero whenever out_valid=0.
- out_data  out  DATA_W  head data.
- stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Handshake definitions:
  - Accept = in_valid & in_ready.
  - Issue = out_valid & out_ready.
  - in_valid/in_ctrl/in_data may change freely while in_ready=0.
  - out_valid, once high, stays high with stable out_ctrl/out_data until issued or flushed.
- Reset (async): state EMPTY; out_valid=0, out_ctrl=0, out_data=0, skid contents=0, stall_cnt=0, in_ready=0 while rst is high.
- Latency: 1 cycle from accept to out_valid when EMPTY. Throughput 1 per cycle when out_ready is held at 1.
- SKID_EN=1, states EMPTY / ONE / TWO (main slot, plus skid slot in TWO):
  - in_ready = (state != TWO). This is purely registered; there is no combinational path from out_ready.
  - EMPTY: accept -> load main, go to ONE.
  - ONE, accept and issue: load main, stay ONE.
  - ONE, issue only: go to EMPTY.
  - ONE, accept only: load skid, go to TWO.
  - ONE, neither: hold.
  - TWO, issue: main <= skid, go to ONE. No accept is possible in TWO.
  - Entries leave in arrival order; the skid entry never overtakes main.
- SKID_EN=0, states EMPTY / ONE:
  - in_ready = !out_valid | out_ready.
  - Load main on accept.
  - This is a combinational ready path; it is documented as such for timing.
- Flush has the highest priority:
  - Next state EMPTY; main and skid invalidated; any input presented that cycle is discarded.
  - in_ready follows the normal rule, so an accepted-and-dropped handshake is legal.
  - out_ctrl reads 0 from the next cycle. out_data is held, or cleared if ZERO_DATA=1.
  - An issue occurring in the same cycle as flush still completes; downstream sampled it.
- Bubble control: when out_valid=0, out_ctrl=0. This guarantees mem_wr/reg_wr are deasserted on bubbles regardless of stale register contents.
- stall_cnt: increments each cycle with out_valid & !out_ready. It saturates at 2^CNT_W-1, is not cleared by flush, and is cleared only by rst.
- Reset deasserted mid-stream: the first accept is possible in the cycle after rst falls.

Decomposition:
- Package pipe_pkg:
  - State encoding: EMPTY=2'd0, ONE=2'd1, TWO=2'd2.
  - ID/EX control field bit positions: CTRL_ULA_LSB=0, CTRL_MUX_ULA=2, CTRL_MEM_RD=3, CTRL_MEM_WR=4, CTRL_REG_WR=5, CTRL_MUX_REG_WR=6.
  - ID/EX data field offsets and widths.
- Sub-module pipe_slot: CTRL_W+DATA_W register with load enable and clear. Instantiated once for main and once for skid (skid only when SKID_EN=1).

Test Plan:
- Reset, then one write:
  - Stimulus: rst pulse; in_valid=1, in_ctrl=8'h24, in_data=144'hA5, out_ready=1.
  - Response: out_valid=1 and out_ctrl=8'h24 one cycle later; out_valid=0 and out_ctrl=0 the next cycle; stall_cnt=0.
- Backpressure fill:
  - Stimulus: out_ready=0; push ctrl 8'h01, then 8'h02.
  - Response: state TWO, in_ready=0, out_ctrl=8'h01.
  - Then raise out_ready: 8'h01 issues, then 8'h02; stall_cnt equals the number of stalled cycles.
- Flush with TWO full and in_valid=1 (ctrl 8'h30):
  - Response: next cycle out_valid=0, out_ctrl=0, in_ready=1; 8'h30 never appears on the output.
- Streaming:
  - Stimulus: 100 back-to-back entries with data = index, out_ready=1.
  - Response: outputs in order 0..99 with no gaps and in_ready=1 throughout.
- Random handshake:
  - Stimulus: random in_valid/out_ready/flush against a reference queue model; also run with SKID_EN=0.
  - Response: no loss, no duplication, in order; every flush empties the queue; mem_wr/reg_wr bits stay 0 whenever out_valid=0.
- Counter saturation with CNT_W=4:
  - Stimulus: hold out_valid=1, out_ready=0 for 20 cycles.
  - Response: stall_cnt stops at 15. An async rst in mid-cycle clears it to 0 immediately.
